// File: rtl/alu_operand_shifter.sv
// alu_operand_shifter: ARM7TDMI barrel shifter feeding the ALU through a registered valid/ready stage; define REGSHIFT_FAST_EN for single-cycle register shifts
module alu_operand_shifter #(
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_rn,
  input  logic [31:0]           in_rm,
  input  logic [7:0]            in_rs,
  input  logic [4:0]            in_shift_imm,
  input  logic [1:0]            in_shift_type,
  input  logic                  in_shift_reg,
  input  logic [CTRL_WIDTH-1:0] in_alu_control,
  input  logic                  in_carry,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           operand_a,
  output logic [31:0]           operand_b,
  output logic [CTRL_WIDTH-1:0] alu_control,
  output logic                  shifter_carry
);
  typedef enum logic [1:0] {IDLE, REGSHIFT, FULL} state_t;
  typedef struct packed {
    logic [31:0]           rn;
    logic [31:0]           rm;
    logic [7:0]            amt;
    logic [1:0]            st;
    logic                  rg;
    logic                  c;
    logic [CTRL_WIDTH-1:0] ctrl;
  } op_t;
  state_t                state_q, state_d;
  op_t                   in_op, sh_op;
  logic                  accept, load, rrx, cy;
  logic [7:0]            eff;
  logic [32:0]           lsl_w, lsr_w, asr_w;
  logic [31:0]           res;
  logic [31:0]           operand_a_q, operand_a_d, operand_b_q, operand_b_d;
  logic [CTRL_WIDTH-1:0] alu_control_q, alu_control_d;
  logic                  shifter_carry_q, shifter_carry_d;
`ifndef REGSHIFT_FAST_EN
  op_t                   pend_q, pend_d;
`endif
  always_comb begin
    in_op = '{rn: in_rn, rm: in_rm, amt: in_shift_reg ? in_rs : {3'b0, in_shift_imm},
              st: in_shift_type, rg: in_shift_reg, c: in_carry, ctrl: in_alu_control};
    in_ready = state_q == IDLE || (state_q == FULL && out_ready);
    accept = in_valid && in_ready;
`ifdef REGSHIFT_FAST_EN
    sh_op = in_op;
    load = accept;
    state_d = accept ? FULL : (state_q == FULL && out_ready) ? IDLE : state_q;
`else
    sh_op = state_q == REGSHIFT ? pend_q : in_op;
    load = state_q == REGSHIFT || (accept && !in_shift_reg);
    pend_d = accept ? in_op : pend_q;
    state_d = state_q == REGSHIFT ? FULL
            : accept ? (in_shift_reg ? REGSHIFT : FULL)
            : (state_q == FULL && out_ready) ? IDLE : state_q;
`endif
  end
  always_comb begin
    rrx = !sh_op.rg && sh_op.amt == 8'd0 && sh_op.st == 2'b11;
    eff = (!sh_op.rg && sh_op.amt == 8'd0 && ^sh_op.st) ? 8'd32 : sh_op.amt;
    lsl_w = {1'b0, sh_op.rm} << eff;
    lsr_w = {sh_op.rm, 1'b0} >> eff;
    asr_w = $signed({sh_op.rm, 1'b0}) >>> eff;
    res = sh_op.st == 2'd0 ? lsl_w[31:0]
        : sh_op.st == 2'd1 ? lsr_w[32:1]
        : sh_op.st == 2'd2 ? asr_w[32:1]
        : rrx ? {sh_op.c, sh_op.rm[31:1]}
        : (sh_op.rm >> eff[4:0]) | (sh_op.rm << (6'd32 - {1'b0, eff[4:0]}));
    cy = (eff == 8'd0 && !rrx) ? sh_op.c
       : sh_op.st == 2'd0 ? lsl_w[32]
       : sh_op.st == 2'd1 ? lsr_w[0]
       : sh_op.st == 2'd2 ? asr_w[0]
       : rrx ? sh_op.rm[0] : res[31];
    operand_a_d = load ? sh_op.rn : operand_a_q;
    operand_b_d = load ? res : operand_b_q;
    alu_control_d = load ? sh_op.ctrl : alu_control_q;
    shifter_carry_d = load ? cy : shifter_carry_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      operand_a_q <= '0;
      operand_b_q <= '0;
      alu_control_q <= '0;
      shifter_carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      alu_control_q <= alu_control_d;
      shifter_carry_q <= shifter_carry_d;
    end
`ifndef REGSHIFT_FAST_EN
    pend_q <= pend_d;
`endif
  end
  assign out_valid = state_q == FULL;
  assign operand_a = operand_a_q;
  assign operand_b = operand_b_q;
  assign alu_control = alu_control_q;
  assign shifter_carry = shifter_carry_q;
endmodule

// File: tb/tb_alu_operand_shifter.sv
// tb_alu_operand_shifter: directed vectors checked against a rule-level shifter model and a result scoreboard
module tb_alu_operand_shifter;
  localparam int CW = 4;
`ifdef REGSHIFT_FAST_EN
  localparam int REG_EXTRA = 0;
`else
  localparam int REG_EXTRA = 1;
`endif
  logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, in_shift_reg, in_carry, shifter_carry;
  logic [31:0]   in_rn, in_rm, operand_a, operand_b;
  logic [7:0]    in_rs;
  logic [4:0]    in_shift_imm;
  logic [1:0]    in_shift_type;
  logic [CW-1:0] in_alu_control, alu_control;
  int            vectors = 0, miscompares = 0, cyc = 0, acc_cyc = 0;
  logic [68:0]   q[$];
  alu_operand_shifter #(.CTRL_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rn(in_rn), .in_rm(in_rm), .in_rs(in_rs), .in_shift_imm(in_shift_imm),
    .in_shift_type(in_shift_type), .in_shift_reg(in_shift_reg),
    .in_alu_control(in_alu_control), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .operand_a(operand_a),
    .operand_b(operand_b), .alu_control(alu_control), .shifter_carry(shifter_carry)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [32:0] ref_shift(input logic [31:0] rm, input logic [7:0] rs,
      input logic [4:0] imm, input logic [1:0] st, input logic rg, input logic c);
    int n, k;
    logic [31:0] r;
    logic co;
    n = rg ? int'(rs) : int'(imm);
    r = rm;
    co = c;
    if (!rg && n == 0) begin
      case (st)
        2'd0: begin r = rm; co = c; end
        2'd1: begin r = 32'h0; co = rm[31]; end
        2'd2: begin r = {32{rm[31]}}; co = rm[31]; end
        default: begin r = {c, rm[31:1]}; co = rm[0]; end
      endcase
    end else if (n != 0) begin
      case (st)
        2'd0: if (n < 32) begin r = rm << n; co = rm[32-n]; end
              else begin r = 32'h0; co = (n == 32) ? rm[0] : 1'b0; end
        2'd1: if (n < 32) begin r = rm >> n; co = rm[n-1]; end
              else begin r = 32'h0; co = (n == 32) ? rm[31] : 1'b0; end
        2'd2: if (n < 32) begin r = 32'($signed(rm) >>> n); co = rm[n-1]; end
              else begin r = {32{rm[31]}}; co = rm[31]; end
        default: begin
          k = n % 32;
          if (k == 0) begin r = rm; co = rm[31]; end
          else begin r = (rm >> k) | (rm << (32 - k)); co = rm[k-1]; end
        end
      endcase
    end
    return {co, r};
  endfunction
  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic scramble();
    in_rn = $urandom;
    in_rm = $urandom;
    in_rs = 8'($urandom);
    in_shift_imm = 5'($urandom);
    in_shift_type = 2'($urandom);
    in_shift_reg = 1'($urandom);
    in_alu_control = CW'($urandom);
    in_carry = 1'($urandom);
  endtask
  task automatic send(input logic [31:0] rn, input logic [31:0] rm, input logic [7:0] rs,
      input logic [4:0] imm, input logic [1:0] st, input logic rg, input logic [CW-1:0] ctl,
      input logic c);
    logic [32:0] r;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_rn = rn;
    in_rm = rm;
    in_rs = rs;
    in_shift_imm = imm;
    in_shift_type = st;
    in_shift_reg = rg;
    in_alu_control = ctl;
    in_carry = c;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) begin
      check("accept_timeout", 72'(in_ready), 72'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    r = ref_shift(rm, rs, imm, st, rg, c);
    q.push_back({rn, r[31:0], ctl, r[32]});
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    scramble();
  endtask
  task automatic wait_valid(output int extra, input logic exp_rdy);
    int n;
    n = 0;
    @(negedge clk);
    check("in_ready_after_accept", 72'(in_ready), 72'(exp_rdy));
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    extra = cyc - acc_cyc;
    if (!out_valid) check("valid_timeout", 72'(out_valid), 72'(1));
  endtask
  task automatic one(input string name, input logic [31:0] rn, input logic [31:0] rm,
      input logic [7:0] rs, input logic [4:0] imm, input logic [1:0] st, input logic rg,
      input logic [CW-1:0] ctl, input logic c, input logic [31:0] eb, input logic ec);
    int extra;
    send(rn, rm, rs, imm, st, rg, ctl, c);
    wait_valid(extra, rg ? logic'(REG_EXTRA == 0) : 1'b1);
    check({name, "_latency"}, 72'(extra), rg ? 72'(REG_EXTRA) : 72'(0));
    check(name, {operand_a, operand_b, alu_control, shifter_carry}, {rn, eb, ctl, ec});
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) check("spurious_valid", 72'(out_valid), 72'(0));
      else begin
        check("scoreboard", {operand_a, operand_b, alu_control, shifter_carry}, q[0]);
        if (out_ready) void'(q.pop_front());
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] ramt [6];
    logic [4:0] iamt [3];
    int extra, c0;
    ramt = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd255};
    iamt = '{5'd0, 5'd1, 5'd31};
    scramble();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {out_valid, in_ready, operand_a, operand_b, alu_control, shifter_carry},
          {1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0});
    check("pin_lsr_imm0", ref_shift(32'h80000001, 8'd0, 5'd0, 2'd1, 1'b0, 1'b0), {1'b1, 32'h0});
    check("pin_ror_rs36", ref_shift(32'hF, 8'd36, 5'd0, 2'd3, 1'b1, 1'b0), {1'b1, 32'hF0000000});
    check("pin_lsl_rs33", ref_shift(32'hF, 8'd33, 5'd0, 2'd0, 1'b1, 1'b1), {1'b0, 32'h0});
    check("pin_asr_imm4", ref_shift(32'h80000010, 8'd0, 5'd4, 2'd2, 1'b0, 1'b0), {1'b0, 32'hF8000001});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    one("imm_lsl0", 32'd10, 32'd20, 8'd0, 5'd0, 2'd0, 1'b0, 4'h0, 1'b1, 32'd20, 1'b1);
    one("imm_lsr0", 32'd1, 32'h80000001, 8'd0, 5'd0, 2'd1, 1'b0, 4'h1, 1'b0, 32'h0, 1'b1);
    one("imm_asr0", 32'd2, 32'h80000001, 8'd0, 5'd0, 2'd2, 1'b0, 4'h2, 1'b0, 32'hFFFFFFFF, 1'b1);
    one("imm_rrx", 32'd3, 32'h80000001, 8'd0, 5'd0, 2'd3, 1'b0, 4'h3, 1'b0, 32'h40000000, 1'b1);
    one("imm_lsl31", 32'd8, 32'h3, 8'd0, 5'd31, 2'd0, 1'b0, 4'h8, 1'b0, 32'h80000000, 1'b1);
    one("reg_lsl32", 32'd4, 32'hF, 8'd32, 5'd0, 2'd0, 1'b1, 4'h4, 1'b0, 32'h0, 1'b1);
    one("reg_lsl33", 32'd5, 32'hF, 8'd33, 5'd0, 2'd0, 1'b1, 4'h5, 1'b1, 32'h0, 1'b0);
    one("reg_ror36", 32'd6, 32'hF, 8'd36, 5'd0, 2'd3, 1'b1, 4'h6, 1'b0, 32'hF0000000, 1'b1);
    one("reg_s0", 32'd7, 32'h1234, 8'd0, 5'd0, 2'd1, 1'b1, 4'h7, 1'b1, 32'h1234, 1'b1);
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 6; k++)
        send($urandom, $urandom, ramt[k], 5'($urandom), 2'(t), 1'b1, CW'($urandom), 1'($urandom));
      for (int k = 0; k < 3; k++)
        send($urandom, $urandom, 8'($urandom), iamt[k], 2'(t), 1'b0, CW'($urandom), 1'($urandom));
    end
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(32'h11, 32'h12345678, 8'd0, 5'd4, 2'd0, 1'b0, 4'h9, 1'b0);
    wait_valid(extra, 1'b0);
    check("hold_latency", 72'(extra), 72'(0));
    repeat (3) begin
      @(negedge clk);
      check("hold", {out_valid, in_ready, operand_a, operand_b, alu_control, shifter_carry},
            {1'b1, 1'b0, 32'h11, 32'h23456780, 4'h9, 1'b1});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h22, 32'hF0, 8'd0, 5'd4, 2'd1, 1'b0, 4'hA, 1'b1);
    @(negedge clk);
    check("drain_and_accept", {out_valid, operand_a, operand_b, shifter_carry},
          {1'b1, 32'h22, 32'hF, 1'b0});
    @(posedge clk);
    #1;
    send(32'h100, 32'h1, 8'd0, 5'd1, 2'd0, 1'b0, 4'h1, 1'b0);
    c0 = acc_cyc;
    send(32'h101, 32'h2, 8'd0, 5'd1, 2'd1, 1'b0, 4'h2, 1'b0);
    send(32'h102, 32'h4, 8'd0, 5'd2, 2'd2, 1'b0, 4'h3, 1'b1);
    send(32'h103, 32'h8, 8'd0, 5'd3, 2'd3, 1'b0, 4'h4, 1'b0);
    check("stream4_cycles", 72'(acc_cyc - c0), 72'(3));
    send(32'h200, 32'hA5A5A5A5, 8'd0, 5'd7, 2'd3, 1'b0, 4'h5, 1'b0);
    c0 = acc_cyc;
    send(32'h201, 32'h5A5A5A5A, 8'd9, 5'd0, 2'd0, 1'b1, 4'h6, 1'b1);
    send(32'h202, 32'hDEADBEEF, 8'd0, 5'd16, 2'd1, 1'b0, 4'h7, 1'b0);
    check("mixed_cycles", 72'(acc_cyc - c0), 72'(2 + REG_EXTRA));
    repeat (2) @(posedge clk);
    #1;
    send(32'h33, 32'hFFFF, 8'd8, 5'd0, 2'd0, 1'b1, 4'hF, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check("reset_mid_regshift", {out_valid, in_ready, operand_a, operand_b, alu_control, shifter_carry},
          {1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0});
    @(negedge clk);
    check("reset_stays_empty", 72'(out_valid), 72'(0));
    @(posedge clk);
    #1;
    one("post_reset", 32'h44, 32'h80000000, 8'd0, 5'd31, 2'd2, 1'b0, 4'hC, 1'b0, 32'hFFFFFFFF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 72'(q.size()), 72'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
